// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry in-order FIFO between the ALU and the register file.
// Ports: clk, rst_n; in_valid/in_ready with Result, Negative, ALUControl, RdAddr;
//        wb_valid/wb_ready with wb_data, wb_addr; flag_n, flag_z, drop_cnt.
// Optional: define ALU_WB_ZERO_FLAG_EN to build the zero flag (else flag_z = 0).
module alu_wb_stage #(
    parameter int RD_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [18:0]     Result,
    input  logic            Negative,
    input  logic [4:0]      ALUControl,
    input  logic [RD_W-1:0] RdAddr,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [18:0]     wb_data,
    output logic [RD_W-1:0] wb_addr,
    output logic            flag_n,
    output logic            flag_z,
    output logic [7:0]      drop_cnt
);

    logic [18:0]     data_q [2];
    logic            neg_q  [2];
    logic [RD_W-1:0] addr_q [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count_q;
    logic [1:0]      count_nxt;
    logic            ready_q;

    logic accept;
    logic is_wb;
    logic push;
    logic drop;
    logic pop;

    assign accept = in_valid & in_ready;
    assign is_wb  = (ALUControl <= 5'd9);
    assign push   = accept & is_wb;
    assign drop   = accept & ~is_wb;
    assign pop    = wb_valid & wb_ready;

    assign count_nxt = count_q + {1'b0, push} - {1'b0, pop};

    // Ready comes from a flop so wb_ready never reaches in_ready combinationally.
    assign in_ready = ready_q;
    assign wb_valid = (count_q != 2'd0);
    assign wb_data  = data_q[rd_ptr];
    assign wb_addr  = addr_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            ready_q <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                neg_q[i]  <= 1'b0;
                addr_q[i] <= '0;
            end
        end else begin
            count_q <= count_nxt;
            ready_q <= (count_nxt != 2'd2);
            if (push) begin
                data_q[wr_ptr] <= Result;
                neg_q[wr_ptr]  <= Negative;
                addr_q[wr_ptr] <= RdAddr;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_n <= 1'b0;
        end else if (pop) begin
            flag_n <= neg_q[rd_ptr];
        end
    end

`ifdef ALU_WB_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
        end else if (pop) begin
            flag_z <= (data_q[rd_ptr] == 19'd0);
        end
    end
`else
    assign flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_wb_stage;

    localparam int RD_W = 4;
`ifdef ALU_WB_ZERO_FLAG_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [18:0]     res = '0;
    logic            neg = 1'b0;
    logic [4:0]      op = '0;
    logic [RD_W-1:0] rd = '0;
    logic            wb_valid;
    logic            wb_ready = 1'b0;
    logic [18:0]     wb_data;
    logic [RD_W-1:0] wb_addr;
    logic            flag_n;
    logic            flag_z;
    logic [7:0]      drop_cnt;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [18:0]     d;
        logic            n;
        logic [RD_W-1:0] a;
    } ent_t;

    ent_t mq[$];
    int   m_drop;
    logic m_fn;
    logic m_fz;

    always #5 clk = ~clk;

    alu_wb_stage #(.RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .Result(res), .Negative(neg), .ALUControl(op), .RdAddr(rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_addr(wb_addr),
        .flag_n(flag_n), .flag_z(flag_z), .drop_cnt(drop_cnt)
    );

    function automatic void model_clear();
        mq.delete();
        m_drop = 0;
        m_fn = 1'b0;
        m_fz = 1'b0;
    endfunction

    // One clock of the intended behaviour, using pre-edge occupancy.
    function automatic void model_step();
        bit   acc;
        bit   ret;
        ent_t e;
        acc = in_valid && (mq.size() < 2);
        ret = (mq.size() > 0) && wb_ready;
        if (ret) begin
            e = mq.pop_front();
            m_fn = e.n;
            m_fz = ZEN ? (e.d == 0) : 1'b0;
        end
        if (acc) begin
            if (op < 5'd10) begin
                e.d = res; e.n = neg; e.a = rd;
                mq.push_back(e);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        in_valid = 0;
        wb_ready = 0;
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_clear();
        tick();
    endtask

    task automatic test_reset();
        in_valid = 0;
        wb_ready = 0;
        rst_n = 0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready);
        end
        total++;
        if ({wb_valid, wb_data, wb_addr, flag_n, flag_z} !== '0) begin
            bad++;
            $display("FAIL rst_outs got=%b/%h/%h/%b/%b exp=0",
                     wb_valid, wb_data, wb_addr, flag_n, flag_z);
        end
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt);
        end
        rst_n = 1;
        model_clear();
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        in_valid = 1; res = 19'h00005; neg = 0; op = 5'b00000; rd = 3;
        wb_ready = 1;
        tick();
        in_valid = 0;
        total++;
        if (wb_valid !== 1'b1 || wb_data !== 19'd5 || wb_addr !== 4'd3) begin
            bad++;
            $display("FAIL basic_wb got v=%b d=%h a=%h exp v=1 d=5 a=3",
                     wb_valid, wb_data, wb_addr);
        end
        tick();
        total++;
        if (flag_n !== 1'b0 || flag_z !== 1'b0 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_flags got n=%b z=%b v=%b exp 0/0/0",
                     flag_n, flag_z, wb_valid);
        end
        wb_ready = 0;
    endtask

    task automatic test_back_to_back();
        logic [18:0] vals [3];
        vals[0] = 19'h11111; vals[1] = 19'h22222; vals[2] = 19'h33333;
        wb_ready = 0;
        op = 5'd1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; res = vals[i]; neg = vals[i][18]; rd = 4'(i + 1);
            if (i == 2) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready);
                end
            end
            tick();
        end
        in_valid = 0;
        total++;
        if (wb_data !== vals[0] || wb_addr !== 4'd1) begin
            bad++; $display("FAIL b2b_hold got=%h exp=%h", wb_data, vals[0]);
        end
        wb_ready = 1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (wb_valid !== 1'b1 || wb_data !== vals[i] || wb_addr !== 4'(i + 1)) begin
                bad++;
                $display("FAIL b2b_order%0d got v=%b d=%h exp d=%h",
                         i, wb_valid, wb_data, vals[i]);
            end
            tick();
        end
        total++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_drain got v=%b r=%b exp v=0 r=1", wb_valid, in_ready);
        end
        wb_ready = 0;
    endtask

    task automatic test_drop();
        logic fn0;
        logic fz0;
        apply_reset();
        fn0 = flag_n;
        fz0 = flag_z;
        in_valid = 1; op = 5'b01011; res = 19'h40000; neg = 1; rd = 7;
        tick();
        in_valid = 0;
        total++;
        if (wb_valid !== 1'b0 || drop_cnt !== 8'd1) begin
            bad++;
            $display("FAIL drop_one got v=%b cnt=%0d exp v=0 cnt=1", wb_valid, drop_cnt);
        end
        total++;
        if (flag_n !== fn0 || flag_z !== fz0) begin
            bad++; $display("FAIL drop_flags got n=%b z=%b exp unchanged", flag_n, flag_z);
        end
        in_valid = 1;
        for (int i = 0; i < 300; i++) begin
            op = 5'($urandom_range(10, 31));
            tick();
        end
        in_valid = 0;
        total++;
        if (drop_cnt !== 8'd255 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL drop_sat got cnt=%0d exp=255", drop_cnt);
        end
    endtask

    task automatic test_flags();
        wb_ready = 1;
        in_valid = 1; res = 19'h40000; neg = 1; op = 5'd2; rd = 5;
        tick();
        in_valid = 0;
        tick();
        total++;
        if (flag_n !== 1'b1 || flag_z !== 1'b0) begin
            bad++; $display("FAIL flag_neg got n=%b z=%b exp n=1 z=0", flag_n, flag_z);
        end
        in_valid = 1; res = 19'h0; neg = 0; op = 5'd9; rd = 6;
        tick();
        in_valid = 0;
        tick();
        total++;
        if (flag_n !== 1'b0 || flag_z !== ZEN) begin
            bad++; $display("FAIL flag_zero got n=%b z=%b exp n=0 z=%b", flag_n, flag_z, ZEN);
        end
        wb_ready = 0;
    endtask

    task automatic test_reset_mid();
        wb_ready = 0;
        in_valid = 1; op = 5'd3;
        for (int i = 0; i < 2; i++) begin
            res = 19'(i + 100); neg = 0; rd = 4'(i);
            tick();
        end
        in_valid = 0;
        total++;
        if (wb_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_full got v=%b r=%b exp v=1 r=0", wb_valid, in_ready);
        end
        #2 rst_n = 0;
        #1;
        total++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_async got v=%b r=%b exp 0/0", wb_valid, in_ready);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1;
        wb_ready = 1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_ready got=%b exp=1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wb_valid !== 1'b0) begin
                bad++; $display("FAIL mid_nowb%0d got=%b exp=0", i, wb_valid);
            end
            tick();
        end
        wb_ready = 0;
    endtask

    task automatic test_random();
        ent_t h;
        for (int c = 0; c < 3000; c++) begin
            total++;
            if (in_ready !== (mq.size() < 2) || wb_valid !== (mq.size() > 0)) begin
                bad++;
                $display("FAIL rnd_hs c=%0d got r=%b v=%b exp occ=%0d",
                         c, in_ready, wb_valid, mq.size());
            end
            if (mq.size() > 0) begin
                h = mq[0];
                total++;
                if (wb_data !== h.d || wb_addr !== h.a) begin
                    bad++;
                    $display("FAIL rnd_head c=%0d got %h/%h exp %h/%h",
                             c, wb_data, wb_addr, h.d, h.a);
                end
            end
            total++;
            if (flag_n !== m_fn || flag_z !== m_fz || drop_cnt !== 8'(m_drop)) begin
                bad++;
                $display("FAIL rnd_state c=%0d got n=%b z=%b d=%0d exp n=%b z=%b d=%0d",
                         c, flag_n, flag_z, drop_cnt, m_fn, m_fz, m_drop);
            end
            in_valid = ($urandom_range(0, 3) != 0);
            wb_ready = ($urandom_range(0, 2) != 0);
            res = ($urandom_range(0, 5) == 0) ? 19'd0 : 19'($urandom);
            neg = res[18];
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(10, 31))
                                             : 5'($urandom_range(0, 9));
            rd = 4'($urandom);
            tick();
        end
        in_valid = 0;
        wb_ready = 0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_back_to_back();
        test_flags();
        test_reset_mid();
        test_drop();
        apply_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
